// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types, defaults and key-symbol helper for the RC4 S-box builder
package rc4_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_KEY_BYTES = 3;
  localparam int MAX_W = 256;
  typedef enum logic [3:0] {IDLE, FILL, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE} state_t;
  // Symbol 0 is the most-significant dw bits of the packed key.
  function automatic logic [MAX_W-1:0] key_sym(input logic [MAX_W-1:0] key, input int dw, input int kb, input int n);
    return key >> ((kb - 1 - n) * dw);
  endfunction
endpackage

// File: rtl/rc4_sbox_sched_if.sv
// rc4_sbox_sched_if: control handshake plus single-port S-memory bus
interface rc4_sbox_sched_if #(parameter int DATA_W = 8, parameter int KEY_BYTES = 3);
  logic start, ksa_en, busy, done, mem_wren;
  logic [KEY_BYTES*DATA_W-1:0] key;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_q;
  modport master(output start, ksa_en, key, mem_q, input busy, done, mem_addr, mem_wdata, mem_wren);
  modport slave(input start, ksa_en, key, mem_q, output busy, done, mem_addr, mem_wdata, mem_wren);
endinterface

// File: rtl/rc4_sbox_sched.sv
// rc4_sbox_sched: fills S[i]=i then optionally runs the RC4 key-scheduling swap pass
module rc4_sbox_sched
  import rc4_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  rc4_sbox_sched_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  localparam logic [DATA_W-1:0] LAST = '1;
  state_t state_q;
  logic [DATA_W-1:0] i_q, j_q, si_q, addr_q, wdata_q, j_d;
  logic [KW-1:0] kidx_q;
  logic [CW-1:0] wait_q;
  logic [KEY_BYTES*DATA_W-1:0] key_q;
  logic ksa_q, busy_q, done_q, wren_q;
  assign j_d = j_q + bus.mem_q + DATA_W'(key_sym(MAX_W'(key_q), DATA_W, KEY_BYTES, int'(kidx_q)));
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wren = wren_q;
  // Outputs are loaded on the transition, so they are valid for the whole target state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      si_q <= '0;
      kidx_q <= '0;
      wait_q <= '0;
      key_q <= '0;
      ksa_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wren_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= FILL;
          key_q <= bus.key;
          ksa_q <= bus.ksa_en;
          i_q <= '0;
          j_q <= '0;
          kidx_q <= '0;
          busy_q <= 1'b1;
          wren_q <= 1'b1;
          addr_q <= '0;
          wdata_q <= '0;
        end
        FILL: if (i_q == LAST) begin
          i_q <= '0;
          wren_q <= 1'b0;
          addr_q <= '0;
          state_q <= ksa_q ? RD_I : DONE;
          busy_q <= ksa_q;
          done_q <= !ksa_q;
        end else begin
          i_q <= i_q + 1'b1;
          addr_q <= i_q + 1'b1;
          wdata_q <= i_q + 1'b1;
        end
        RD_I: begin
          state_q <= WAIT_I;
          wait_q <= CW'(RD_LAT - 1);
        end
        WAIT_I: if (wait_q != '0) wait_q <= wait_q - 1'b1;
        else begin
          si_q <= bus.mem_q;
          j_q <= j_d;
          addr_q <= j_d;
          state_q <= RD_J;
        end
        RD_J: begin
          state_q <= WAIT_J;
          wait_q <= CW'(RD_LAT - 1);
        end
        WAIT_J: if (wait_q != '0) wait_q <= wait_q - 1'b1;
        else begin
          wdata_q <= bus.mem_q;
          addr_q <= i_q;
          wren_q <= 1'b1;
          state_q <= WR_I;
        end
        WR_I: begin
          addr_q <= j_q;
          wdata_q <= si_q;
          state_q <= WR_J;
        end
        WR_J: begin
          i_q <= i_q + 1'b1;
          kidx_q <= kidx_q == KW'(KEY_BYTES - 1) ? '0 : kidx_q + 1'b1;
          wren_q <= 1'b0;
          addr_q <= i_q + 1'b1;
          state_q <= i_q == LAST ? DONE : RD_I;
          busy_q <= i_q != LAST;
          done_q <= i_q == LAST;
        end
        default: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          wren_q <= 1'b0;
        end
      endcase
    end
endmodule
